// File: rtl/sample_mac_pipe.sv
// Pipelined signed multiply / multiply-accumulate with a configurable depth and output narrowing.
// A valid bit and the accumulate controls ride alongside the data, and ce stalls every register.
module sample_mac_pipe #(
  parameter int A_WIDTH   = 14,
  parameter int B_WIDTH   = 14,
  parameter int P_WIDTH   = 14,
  parameter int ACC_WIDTH = 32,
  parameter int STAGES    = 2,
  parameter int SAT       = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ce,
  input  logic               in_valid,
  input  logic [A_WIDTH-1:0] din0,
  input  logic [B_WIDTH-1:0] din1,
  input  logic               acc_en,
  input  logic               acc_clr,
  output logic               out_valid,
  output logic [P_WIDTH-1:0] dout,
  output logic               ovf
);

  localparam int M_WIDTH = A_WIDTH + B_WIDTH;
  localparam int DLY     = STAGES - 2;
  localparam int U_WIDTH = ACC_WIDTH - P_WIDTH + 1;
  localparam logic [P_WIDTH-1:0] P_MAX = {1'b0, {(P_WIDTH-1){1'b1}}};
  localparam logic [P_WIDTH-1:0] P_MIN = {1'b1, {(P_WIDTH-1){1'b0}}};

  logic signed [A_WIDTH-1:0]   a_r;
  logic signed [B_WIDTH-1:0]   b_r;
  logic                        v_r, en_r, clr_r;
  logic signed [M_WIDTH-1:0]   a_ext_s, b_ext_s, prod_s;
  logic signed [M_WIDTH-1:0]   fin_prod_s;
  logic                        fin_v_s, fin_en_s, fin_clr_s;
  logic signed [ACC_WIDTH-1:0] acc_r, sext_s, acc_nxt_s, res_s;
  logic [U_WIDTH-1:0]          upper_s;
  logic [P_WIDTH-1:0]          conv_s;
  logic                        ovf_s;
  logic                        out_valid_r, ovf_r;
  logic [P_WIDTH-1:0]          dout_r;

  // Stage 1: capture operands and sideband
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_r   <= {A_WIDTH{1'b0}};
      b_r   <= {B_WIDTH{1'b0}};
      v_r   <= 1'b0;
      en_r  <= 1'b0;
      clr_r <= 1'b0;
    end else if (ce) begin
      a_r   <= din0;
      b_r   <= din1;
      v_r   <= in_valid;
      en_r  <= acc_en;
      clr_r <= acc_clr;
    end
  end

  // Operands are sign-extended first so the product is exact at full width
  assign a_ext_s = M_WIDTH'(a_r);
  assign b_ext_s = M_WIDTH'(b_r);
  assign prod_s  = a_ext_s * b_ext_s;

  generate
    if (DLY > 0) begin : g_dly
      logic signed [M_WIDTH-1:0] prod_d_r [DLY];
      logic [DLY-1:0]            v_d_r, en_d_r, clr_d_r;

      // Product delay line with its sideband bits
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < DLY; i++) prod_d_r[i] <= {M_WIDTH{1'b0}};
          v_d_r   <= {DLY{1'b0}};
          en_d_r  <= {DLY{1'b0}};
          clr_d_r <= {DLY{1'b0}};
        end else if (ce) begin
          prod_d_r[0] <= prod_s;
          v_d_r[0]    <= v_r;
          en_d_r[0]   <= en_r;
          clr_d_r[0]  <= clr_r;
          for (int i = 1; i < DLY; i++) begin
            prod_d_r[i] <= prod_d_r[i-1];
            v_d_r[i]    <= v_d_r[i-1];
            en_d_r[i]   <= en_d_r[i-1];
            clr_d_r[i]  <= clr_d_r[i-1];
          end
        end
      end

      assign fin_prod_s = prod_d_r[DLY-1];
      assign fin_v_s    = v_d_r[DLY-1];
      assign fin_en_s   = en_d_r[DLY-1];
      assign fin_clr_s  = clr_d_r[DLY-1];
    end else begin : g_nodly
      assign fin_prod_s = prod_s;
      assign fin_v_s    = v_r;
      assign fin_en_s   = en_r;
      assign fin_clr_s  = clr_r;
    end
  endgenerate

  assign sext_s = ACC_WIDTH'(fin_prod_s);

  // Accumulator update and full-width result selection
  always_comb begin
    acc_nxt_s = acc_r;
    res_s     = sext_s;
    if (fin_v_s && fin_en_s) begin
      if (fin_clr_s) begin
        acc_nxt_s = sext_s;
      end else begin
        acc_nxt_s = acc_r + sext_s;
      end
      res_s = acc_nxt_s;
    end else begin
      acc_nxt_s = acc_r;
    end
  end

  // Narrow to P_WIDTH: overflow whenever the dropped bits are not a sign extension
  always_comb begin
    upper_s = res_s[ACC_WIDTH-1:P_WIDTH-1];
    ovf_s   = ~((&upper_s) | ~(|upper_s));
    conv_s  = res_s[P_WIDTH-1:0];
    if ((SAT != 0) && ovf_s) begin
      if (res_s[ACC_WIDTH-1]) begin
        conv_s = P_MIN;
      end else begin
        conv_s = P_MAX;
      end
    end else begin
      conv_s = res_s[P_WIDTH-1:0];
    end
  end

  // Final stage: results and accumulator only move on a valid beat
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_r       <= {ACC_WIDTH{1'b0}};
      dout_r      <= {P_WIDTH{1'b0}};
      ovf_r       <= 1'b0;
      out_valid_r <= 1'b0;
    end else if (ce) begin
      out_valid_r <= fin_v_s;
      if (fin_v_s) begin
        acc_r  <= acc_nxt_s;
        dout_r <= conv_s;
        ovf_r  <= ovf_s;
      end
    end
  end

  assign out_valid = out_valid_r;
  assign dout      = dout_r;
  assign ovf       = ovf_r;

endmodule

// File: tb/tb_sample_mac_pipe.sv
// Self-checking bench: three configurations share one stimulus stream and are compared
// against a beat-level arithmetic model with per-beat due times in enabled cycles.
module tb_sample_mac_pipe;

  logic clk, reset, ce, in_valid, acc_en, acc_clr;
  logic signed [13:0] din0, din1;
  logic ov [3];
  logic signed [13:0] dv [3];
  logic of [3];

  int n_chk, n_fail, ecnt, model_acc;
  logic e_ov [3];
  int   e_d  [3];
  logic e_o  [3];

  typedef struct {
    int dw; bit ow; int ds; bit os; int n;
  } beat_t;
  beat_t qa [$];
  beat_t qb [$];

  sample_mac_pipe #(.STAGES(2), .SAT(0)) u0 (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .din0(din0), .din1(din1),
    .acc_en(acc_en), .acc_clr(acc_clr), .out_valid(ov[0]), .dout(dv[0]), .ovf(of[0]));
  sample_mac_pipe #(.STAGES(2), .SAT(1)) u1 (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .din0(din0), .din1(din1),
    .acc_en(acc_en), .acc_clr(acc_clr), .out_valid(ov[1]), .dout(dv[1]), .ovf(of[1]));
  sample_mac_pipe #(.STAGES(5), .SAT(0)) u2 (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .din0(din0), .din1(din1),
    .acc_en(acc_en), .acc_clr(acc_clr), .out_valid(ov[2]), .dout(dv[2]), .ovf(of[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic void narrow(input int r, output int dw, output bit ow,
                                 output int ds, output bit os);
    dw = r & 16383;
    if (dw >= 8192) dw = dw - 16384;
    ow = (dw != r);
    if (r > 8191) begin
      ds = 8191; os = 1'b1;
    end else if (r < -8192) begin
      ds = -8192; os = 1'b1;
    end else begin
      ds = r; os = 1'b0;
    end
  endfunction

  task automatic check_outputs();
    for (int i = 0; i < 3; i++) begin
      check_val($sformatf("out_valid[%0d]", i), ov[i], e_ov[i]);
      check_val($sformatf("dout[%0d]", i), dv[i], e_d[i]);
      check_val($sformatf("ovf[%0d]", i), of[i], e_o[i]);
    end
  endtask

  task automatic clear_model();
    qa.delete();
    qb.delete();
    model_acc = 0;
    for (int i = 0; i < 3; i++) begin
      e_ov[i] = 1'b0; e_d[i] = 0; e_o[i] = 1'b0;
    end
  endtask

  // One clock: update the model with the beat presented, then check all outputs
  task automatic step();
    beat_t b;
    int p, r;
    @(posedge clk);
    if (!reset && ce) begin
      ecnt++;
      if (in_valid) begin
        p = int'(din0) * int'(din1);
        if (!acc_en) begin
          r = p;
        end else if (acc_clr) begin
          model_acc = p; r = p;
        end else begin
          model_acc = model_acc + p; r = model_acc;
        end
        narrow(r, b.dw, b.ow, b.ds, b.os);
        b.n = ecnt;
        qa.push_back(b);
        qb.push_back(b);
      end
      for (int i = 0; i < 3; i++) e_ov[i] = 1'b0;
      if (qa.size() > 0 && qa[0].n + 1 == ecnt) begin
        b = qa.pop_front();
        e_ov[0] = 1'b1; e_d[0] = b.dw; e_o[0] = b.ow;
        e_ov[1] = 1'b1; e_d[1] = b.ds; e_o[1] = b.os;
      end
      if (qb.size() > 0 && qb[0].n + 4 == ecnt) begin
        b = qb.pop_front();
        e_ov[2] = 1'b1; e_d[2] = b.dw; e_o[2] = b.ow;
      end
    end
    #1;
    check_outputs();
  endtask

  task automatic drive(input logic v, input int a, input int b, input logic en, input logic clr);
    in_valid = v; din0 = 14'(a); din1 = 14'(b); acc_en = en; acc_clr = clr;
  endtask

  initial begin
    int accepted, guard;
    n_chk = 0; n_fail = 0; ecnt = 0;
    reset = 1'b1; ce = 1'b0;
    drive(1'b0, 0, 0, 1'b0, 1'b0);
    clear_model();
    step();
    step();

    // single plain multiply
    reset = 1'b0; ce = 1'b1;
    drive(1'b1, 100, 50, 1'b0, 1'b0);
    step();
    drive(1'b0, 0, 0, 1'b0, 1'b0);
    step();
    check_val("mul_100x50", dv[0], 5000);

    // wrap vs saturate
    drive(1'b1, 200, 100, 1'b0, 1'b0);
    step();
    drive(1'b1, -128, 128, 1'b0, 1'b0);
    step();
    check_val("wrap_20000", dv[0], 3616);
    check_val("wrap_ovf", of[0], 1);
    check_val("sat_pos", dv[1], 8191);
    check_val("sat_pos_ovf", of[1], 1);
    drive(1'b0, 0, 0, 1'b0, 1'b0);
    step();
    check_val("sat_neg", dv[1], -8192);
    check_val("sat_neg_ovf", of[1], 1);
    for (int i = 0; i < 4; i++) step();

    // back-to-back accumulation, then reload with acc_clr
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 3, 4, 1'b1, i == 0);
      step();
      if (i > 0) check_val("acc_seq", dv[0], 12 * i);
    end
    drive(1'b1, 5, 5, 1'b1, 1'b1);
    step();
    check_val("acc_seq_last", dv[0], 120);
    drive(1'b0, 0, 0, 1'b0, 1'b0);
    step();
    check_val("acc_reload", dv[0], 25);

    // plain beats interleaved with accumulate beats
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) drive(1'b1, 7, 7, 1'b0, 1'b1);
      else            drive(1'b1, 2, 3, 1'b1, 1'b0);
      step();
    end
    drive(1'b0, 0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step();

    // 20-beat accumulate stream under a random clock enable
    accepted = 0; guard = 0;
    while (accepted < 20 && guard < 1000) begin
      drive(1'b1, $urandom, $urandom, 1'b1, accepted == 0);
      ce = 1'($urandom % 2);
      step();
      if (ce) accepted++;
      guard++;
    end
    check_val("ce_stream_accepted", accepted, 20);
    ce = 1'b1;
    drive(1'b0, 0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step();

    // asynchronous reset with beats in flight
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 11 + i, 9, 1'b1, i == 0);
      step();
    end
    #3;
    reset = 1'b1;
    #1;
    clear_model();
    check_outputs();
    step();
    step();
    ce = 1'b0;
    reset = 1'b0;
    step();
    step();
    ce = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 2, 3, 1'b1, 1'b0);
      step();
      if (i == 1) check_val("post_reset_acc", dv[0], 6);
    end
    drive(1'b0, 0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step();

    // free-running random traffic
    for (int i = 0; i < 200; i++) begin
      drive(1'($urandom % 4 != 0), $urandom, $urandom, 1'($urandom % 2), 1'($urandom % 8 == 0));
      ce = 1'($urandom % 4 != 0);
      step();
    end
    ce = 1'b1;
    drive(1'b0, 0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step();
    check_val("drain_qa", qa.size(), 0);
    check_val("drain_qb", qb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
